ov7670_capture: RTL and testbench
=================================

# ov7670_capture

Camera-side capture block: samples the OV7670 parallel pixel bus (VSYNC/HREF/D[7:0], RGB444 two bytes per pixel) on `pclk`, assembles 12-bit pixels and writes them row-major into the video frame buffer. It is the writer counterpart to the VGA scan-out reader on the same buffer. Address 0 is the top-left pixel and frames are aligned to camera VSYNC.

## Interface
- `RESOLUTION_WIDTH`, 640, active pixels per line
- `RESOLUTION_HEIGHT`, 480, active lines per frame

Ports:
- `pclk`  in  1  camera pixel clock; only clock
- `rst`  in  1  reset, synchronous, active-high
- `cam_vsync`  in  1  camera VSYNC, high during vertical blanking
- `cam_href`  in  1  camera HREF, high while line bytes are valid
- `cam_data`  in  8  camera data byte
- `w_clk`  out  1  buffer write clock, equal to `pclk`
- `w_addr`  out  $clog2(W*H)+1  buffer write address
- `w_data`  out  12  pixel {R[3:0],G[3:0],B[3:0]}
- `w_en`  out  1  write strobe, one cycle per pixel
- `pixel_x`  out  $clog2(W)+1  column of the current `w_data`
- `pixel_y`  out  $clog2(H)+1  row of the current `w_data`
- `frame_done`  out  1  one-cycle pulse when a complete W*H frame has been written
- `frame_err`  out  1  one-cycle pulse when a frame is aborted or malformed

## Operation
- States:
  - SYNC_WAIT: after reset, wait for a `cam_vsync` falling edge, then go to LINE_WAIT. This prevents capture of partial frames.
  - LINE_WAIT: between lines; `cam_href` high goes to BYTE_HI.
  - BYTE_HI: sample the byte and latch R = `cam_data[3:0]`; next state is BYTE_LO.
  - BYTE_LO: sample the byte as {G,B} = `cam_data[7:4]`,`cam_data[3:0]` and emit the pixel; next state is BYTE_HI if `cam_href` is still high, otherwise LINE_WAIT.
- HREF falling edge (1→0, previous cycle high):
  - On an even byte count, increment row and clear column.
  - On an odd byte count (half pixel), discard the latched R. Set a per-frame `bad` flag.
- Column ≥ W: no write, set `bad`. Row ≥ H: no write, set `bad`.
- Write address equals the running pixel count within the frame. It increments by one after each write and is never computed as x + y*W.
- `cam_vsync` rising edge (0→1):
  - If the count equals W*H and `bad` is clear, pulse `frame_done`.
  - Otherwise pulse `frame_err`.
  - In both cases: address, row and column return to 0, `bad` clears, state returns to LINE_WAIT.
- `cam_vsync` high while `cam_href` is high is treated as blanking. No bytes are captured while `cam_vsync` is high.
- Simultaneous HREF fall and VSYNC rise: VSYNC handling wins. The row increment is dropped.
- Reset mid-frame: all outputs go to reset values, state goes to SYNC_WAIT, and the first subsequent frame is ignored until the next VSYNC fall.
- Reset values: `w_addr` 0, `w_data` 0, `w_en` 0, `pixel_x` 0, `pixel_y` 0, `frame_done` 0, `frame_err` 0.

## Timing
- `cam_*` inputs are registered once on entry; edge detection uses the registered copy against a second stage.
- `w_en`, `w_addr`, `w_data`, `pixel_x` and `pixel_y` are registered outputs. They are valid in the same cycle, starting two `pclk` cycles after the edge that presented the LO byte on the pins.
- `frame_done` and `frame_err` assert two cycles after the pin-level VSYNC rise. Their reported count includes any write still in flight.
- Throughput: one write every two cycles while `cam_href` is high. `w_en` is never high on consecutive cycles.
- All outputs change only on `pclk` rising edges. There is no combinational path from inputs to outputs except `w_clk`.

## Structure
- Shared `ov7670_pkg` contains:
  - the state enum type: SYNC_WAIT, LINE_WAIT, BYTE_HI, BYTE_LO;
  - the RGB444 nibble-position constants;
  - a width helper for address and x/y widths, also used by the scan-out block.
- One sub-module, `edge_detect`: a two-flop registered rise/fall detector instantiated for `cam_vsync` and `cam_href`. Everything else is flat.

## Test plan
Tests use W=4, H=2 unless noted.
- Clean frame: VSYNC pulse, then 2 lines × 8 bytes (pixel n bytes 0x0n, 0xnn), then VSYNC rise.
  - Expect 8 `w_en` pulses with `w_addr` 0..7 and `w_data` 0x000, 0x111, … 0x777.
  - Expect `pixel_x`/`pixel_y` to follow.
  - Expect one `frame_done` and no `frame_err`.
- Startup mid-frame: release `rst` while HREF is active before the first VSYNC.
  - Expect no `w_en` until after the VSYNC fall.
  - The next full frame then produces `frame_done`.
- Odd line: line 0 carries 7 bytes.
  - Expect 3 writes, then line 1 starting at `w_addr` 3 with `pixel_y`=1.
  - At VSYNC rise, expect `frame_err` and no `frame_done`.
- Overlong frame: 5 pixels per line and 3 lines.
  - Expect only 8 writes, with addresses 0..7 and no address past 7.
  - Expect `frame_err`.
- Reset mid-line: assert `rst` after 2 pixels of line 0.
  - Expect all outputs 0 on the next cycle.
  - Expect no writes until the next VSYNC fall; the subsequent clean frame starts at `w_addr` 0.
- Back-to-back frames with VSYNC rise in the same cycle as the last HREF fall:
  - Expect `frame_done` for frame 1.
  - Expect frame 2 writes to start again at `w_addr` 0.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path and the frame-buffer readers.
package ov7670_pkg;

   // Capture sequencer states.
   typedef enum logic [1:0] {
      SYNC_WAIT,
      LINE_WAIT,
      BYTE_HI,
      BYTE_LO
   } cap_state_t;

   // RGB444 on the bus: first byte carries R in its low nibble, second byte is {G,B}.
   localparam int HI_R_MSB = 3;
   localparam int HI_R_LSB = 0;
   localparam int LO_G_MSB = 7;
   localparam int LO_G_LSB = 4;
   localparam int LO_B_MSB = 3;
   localparam int LO_B_LSB = 0;
   localparam int PIX_W    = 12;

   // Counter width able to hold the value n itself (not just 0..n-1).
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/ov7670_capture_if.sv
// Camera pins in, frame-buffer write port out. The capture block is the master.
interface ov7670_capture_if
   import ov7670_pkg::*;
#(
   parameter int W = 640,
   parameter int H = 480
);
   localparam int AW = cnt_width(W * H);
   localparam int XW = cnt_width(W);
   localparam int YW = cnt_width(H);

   logic             cam_vsync;
   logic             cam_href;
   logic [7:0]       cam_data;
   logic             w_clk;
   logic [AW-1:0]    w_addr;
   logic [PIX_W-1:0] w_data;
   logic             w_en;
   logic [XW-1:0]    pixel_x;
   logic [YW-1:0]    pixel_y;
   logic             frame_done;
   logic             frame_err;

   modport master (
      input  cam_vsync, cam_href, cam_data,
      output w_clk, w_addr, w_data, w_en, pixel_x, pixel_y, frame_done, frame_err
   );

   modport slave (
      output cam_vsync, cam_href, cam_data,
      input  w_clk, w_addr, w_data, w_en, pixel_x, pixel_y, frame_done, frame_err
   );
endinterface

// File: rtl/edge_detect.sv
// Two-flop registered edge detector; level_o is the first (registered) stage.
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic s1_q;
   logic s2_q;

   // Register the pin, then keep one more stage to compare against.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
      end
   end

   assign level_o = s1_q;
   assign rise_o  = s1_q & ~s2_q;
   assign fall_o  = ~s1_q & s2_q;
endmodule

// File: rtl/ov7670_capture.sv
// OV7670 RGB444 capture: assembles byte pairs into 12-bit pixels and writes them
// row-major into the frame buffer, address = running pixel count of the frame.
//
//   state     | meaning
//   SYNC_WAIT | after reset, ignore everything until a VSYNC fall
//   LINE_WAIT | between lines; an HREF rise means the byte in hand is a HI byte
//   BYTE_HI   | byte in hand is a HI byte (R nibble)
//   BYTE_LO   | byte in hand is a LO byte ({G,B}); R is latched
module ov7670_capture
   import ov7670_pkg::*;
#(
   parameter int RESOLUTION_WIDTH  = 640,
   parameter int RESOLUTION_HEIGHT = 480
) (
   input logic              pclk,
   input logic              rst,
   ov7670_capture_if.master bus
);
   localparam int W  = RESOLUTION_WIDTH;
   localparam int H  = RESOLUTION_HEIGHT;
   localparam int AW = cnt_width(W * H);
   localparam int XW = cnt_width(W);
   localparam int YW = cnt_width(H);

   logic vs_lvl, vs_rise, vs_fall;
   logic hr_lvl, hr_rise, hr_fall;
   logic [7:0] d_q;

   cap_state_t       state_q;
   logic [3:0]       r_q;
   logic [AW-1:0]    count_q;
   logic [XW-1:0]    col_q;
   logic [YW-1:0]    row_q;
   logic             bad_q;
   logic             w_en_q;
   logic [AW-1:0]    w_addr_q;
   logic [PIX_W-1:0] w_data_q;
   logic [XW-1:0]    px_q;
   logic [YW-1:0]    py_q;
   logic             done_q;
   logic             err_q;

   edge_detect u_vsync (
      .clk    (pclk),
      .rst    (rst),
      .sig_i  (bus.cam_vsync),
      .level_o(vs_lvl),
      .rise_o (vs_rise),
      .fall_o (vs_fall)
   );

   edge_detect u_href (
      .clk    (pclk),
      .rst    (rst),
      .sig_i  (bus.cam_href),
      .level_o(hr_lvl),
      .rise_o (hr_rise),
      .fall_o (hr_fall)
   );

   // Data byte registered alongside the first stage of the sync detectors.
   always_ff @(posedge pclk) begin
      if (rst) d_q <= '0;
      else     d_q <= bus.cam_data;
   end

   // Capture sequencer; VSYNC handling takes priority over any line event.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q  <= SYNC_WAIT;
         r_q      <= '0;
         count_q  <= '0;
         col_q    <= '0;
         row_q    <= '0;
         bad_q    <= 1'b0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
         px_q     <= '0;
         py_q     <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         w_en_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state_q == SYNC_WAIT) begin
            if (vs_fall) begin
               state_q <= LINE_WAIT;
               count_q <= '0;
               col_q   <= '0;
               row_q   <= '0;
               bad_q   <= 1'b0;
            end
         end else if (vs_rise) begin
            // count_q already includes a write issued on the previous edge
            if (count_q == AW'(W * H) && !bad_q) done_q <= 1'b1;
            else                                 err_q  <= 1'b1;
            state_q <= LINE_WAIT;
            count_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            bad_q   <= 1'b0;
         end else if (vs_lvl) begin
            state_q <= LINE_WAIT;
         end else if (hr_fall && state_q != LINE_WAIT) begin
            // ending in BYTE_LO means an R nibble with no {G,B}: drop it
            if (state_q == BYTE_LO) bad_q <= 1'b1;
            if (row_q < YW'(H)) row_q <= row_q + YW'(1);
            col_q   <= '0;
            state_q <= LINE_WAIT;
         end else begin
            case (state_q)
               LINE_WAIT: begin
                  if (hr_rise) begin
                     r_q     <= d_q[HI_R_MSB:HI_R_LSB];
                     state_q <= BYTE_LO;
                  end
               end
               BYTE_HI: begin
                  if (hr_lvl) begin
                     r_q     <= d_q[HI_R_MSB:HI_R_LSB];
                     state_q <= BYTE_LO;
                  end else begin
                     state_q <= LINE_WAIT;
                  end
               end
               BYTE_LO: begin
                  if (hr_lvl) begin
                     if (col_q < XW'(W) && row_q < YW'(H)) begin
                        w_en_q   <= 1'b1;
                        w_addr_q <= count_q;
                        w_data_q <= {r_q, d_q[LO_G_MSB:LO_G_LSB], d_q[LO_B_MSB:LO_B_LSB]};
                        px_q     <= col_q;
                        py_q     <= row_q;
                        count_q  <= count_q + AW'(1);
                     end else begin
                        bad_q <= 1'b1;
                     end
                     if (col_q < XW'(W)) col_q <= col_q + XW'(1);
                     state_q <= BYTE_HI;
                  end else begin
                     state_q <= LINE_WAIT;
                  end
               end
               default: state_q <= SYNC_WAIT;
            endcase
         end
      end
   end

   assign bus.w_clk      = pclk;
   assign bus.w_en       = w_en_q;
   assign bus.w_addr     = w_addr_q;
   assign bus.w_data     = w_data_q;
   assign bus.pixel_x    = px_q;
   assign bus.pixel_y    = py_q;
   assign bus.frame_done = done_q;
   assign bus.frame_err  = err_q;
endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture at W=4, H=2. Frames are described as byte lists per
// line; the reference model derives the expected writes and frame verdicts.
module tb_ov7670_capture;
   import ov7670_pkg::*;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int AW = cnt_width(W * H);
   localparam int XW = cnt_width(W);
   localparam int YW = cnt_width(H);

   typedef struct packed {
      logic [AW-1:0] a;
      logic [11:0]   d;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } wr_t;

   logic pclk = 1'b0;
   logic rst  = 1'b1;

   ov7670_capture_if #(.W(W), .H(H)) bus ();

   ov7670_capture #(.RESOLUTION_WIDTH(W), .RESOLUTION_HEIGHT(H)) dut (
      .pclk(pclk),
      .rst (rst),
      .bus (bus)
   );

   always #5 pclk = ~pclk;

   int total = 0;
   int nbad  = 0;

   // observed activity
   wr_t  got[$];
   int   done_cnt = 0;
   int   err_cnt  = 0;
   int   consec   = 0;
   logic prev_en  = 1'b0;

   always @(negedge pclk) begin
      if (bus.w_en) got.push_back(wr_t'({bus.w_addr, bus.w_data, bus.pixel_x, bus.pixel_y}));
      if (bus.frame_done) done_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.w_en && prev_en) consec++;
      prev_en = bus.w_en;
   end

   // frame description and model expectations
   logic [7:0] fbytes[$];
   int         flen[$];
   wr_t        exp[$];
   int         exp_done;
   int         exp_err;

   task automatic new_frame();
      flen.delete();
      fbytes.delete();
   endtask

   task automatic add_line(input int len, input bit pattern);
      logic [3:0] n;
      for (int b = 0; b < len; b++) begin
         n = 4'(fbytes.size() / 2);
         if (pattern) fbytes.push_back((fbytes.size() % 2 == 0) ? {4'h0, n} : {n, n});
         else         fbytes.push_back(8'($urandom));
      end
      flen.push_back(len);
   endtask

   // Pixel k of line y lands at the next running address if it fits in W x H.
   task automatic model_frame();
      int   addr = 0;
      int   off  = 0;
      bit   bad  = 0;
      logic [7:0] hi, lo;
      for (int y = 0; y < flen.size(); y++) begin
         if (flen[y] % 2 != 0) bad = 1;
         for (int i = 0; i < flen[y] / 2; i++) begin
            hi = fbytes[off + 2*i];
            lo = fbytes[off + 2*i + 1];
            if (i < W && y < H) begin
               exp.push_back(wr_t'({AW'(addr), hi[3:0], lo, XW'(i), YW'(y)}));
               addr++;
            end else begin
               bad = 1;
            end
         end
         off += flen[y];
      end
      if (addr == W * H && !bad) exp_done++;
      else                       exp_err++;
   endtask

   // Drives a whole frame starting from VSYNC high; optionally raises VSYNC
   // on the same edge as the final HREF fall.
   task automatic run_frame(input bit vs_with_fall);
      int off = 0;
      repeat (3) @(negedge pclk);
      bus.cam_vsync = 1'b0;
      repeat (3) @(negedge pclk);
      for (int l = 0; l < flen.size(); l++) begin
         for (int b = 0; b < flen[l]; b++) begin
            @(negedge pclk);
            bus.cam_href = 1'b1;
            bus.cam_data = fbytes[off + b];
         end
         off += flen[l];
         @(negedge pclk);
         bus.cam_href = 1'b0;
         bus.cam_data = 8'($urandom);
         if (vs_with_fall && l == flen.size() - 1) bus.cam_vsync = 1'b1;
         repeat ($urandom_range(1, 4)) @(negedge pclk);
      end
      bus.cam_vsync = 1'b1;
      repeat (5) @(negedge pclk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge pclk);
      total++;
      if ({bus.w_addr, bus.w_data, bus.w_en, bus.pixel_x, bus.pixel_y, bus.frame_done, bus.frame_err} !== '0) begin
         nbad++;
         $display("FAIL reset_outputs got a=%h d=%h en=%b x=%h y=%h done=%b err=%b want all 0",
                  bus.w_addr, bus.w_data, bus.w_en, bus.pixel_x, bus.pixel_y, bus.frame_done, bus.frame_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_clean_frame();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      add_line(8, 1);
      add_line(8, 1);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL clean count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL clean write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL clean done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL clean err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL clean back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_startup_midframe();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      @(negedge pclk);
      rst = 1'b1; bus.cam_vsync = 1'b0; bus.cam_href = 1'b0;
      repeat (3) @(negedge pclk);
      for (int b = 0; b < 8; b++) begin
         @(negedge pclk);
         bus.cam_href = 1'b1; bus.cam_data = 8'($urandom);
         if (b == 3) rst = 1'b0;
      end
      @(negedge pclk) bus.cam_href = 1'b0;
      repeat (3) @(negedge pclk);
      for (int b = 0; b < 8; b++) begin
         @(negedge pclk);
         bus.cam_href = 1'b1; bus.cam_data = 8'($urandom);
      end
      @(negedge pclk) bus.cam_href = 1'b0;
      repeat (3) @(negedge pclk);
      bus.cam_vsync = 1'b1;
      repeat (5) @(negedge pclk);
      total++; if (got.size() != gb) begin nbad++; $display("FAIL startup writes_before_sync got=%0d want=0", got.size() - gb); end
      total++; if (done_cnt + err_cnt != db + eb) begin nbad++; $display("FAIL startup pulses_before_sync got=%0d want=0", done_cnt + err_cnt - db - eb); end
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      add_line(8, 0);
      add_line(8, 0);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL startup count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL startup write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL startup done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL startup err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL startup back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_odd_line();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      add_line(7, 0);
      add_line(8, 0);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL odd count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL odd write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL odd done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL odd err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL odd back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_overlong();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      repeat (3) add_line(10, 0);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL overlong count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL overlong write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL overlong done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL overlong err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL overlong back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_reset_midline();
      int gb, db, eb, cb;
      logic [7:0] b[6];
      wr_t w0, w1;
      @(negedge pclk) bus.cam_vsync = 1'b0;
      repeat (3) @(negedge pclk);
      gb = got.size(); db = done_cnt; eb = err_cnt; cb = consec;
      foreach (b[i]) b[i] = 8'($urandom);
      w0 = wr_t'({AW'(0), b[0][3:0], b[1], XW'(0), YW'(0)});
      w1 = wr_t'({AW'(1), b[2][3:0], b[3], XW'(1), YW'(0)});
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         bus.cam_href = 1'b1; bus.cam_data = b[i];
      end
      @(negedge pclk);
      bus.cam_data = b[5]; rst = 1'b1;
      @(negedge pclk);
      total++;
      if ({bus.w_addr, bus.w_data, bus.w_en, bus.pixel_x, bus.pixel_y, bus.frame_done, bus.frame_err} !== '0) begin
         nbad++;
         $display("FAIL midreset_outputs got a=%h d=%h en=%b x=%h y=%h done=%b err=%b want all 0",
                  bus.w_addr, bus.w_data, bus.w_en, bus.pixel_x, bus.pixel_y, bus.frame_done, bus.frame_err);
      end
      total++;
      if (got.size() - gb != 2) begin nbad++; $display("FAIL midreset pre_count got=%0d want=2", got.size() - gb); end
      else begin
         total++; if (got[gb] !== w0) begin nbad++; $display("FAIL midreset write0 got=%h want=%h", got[gb], w0); end
         total++; if (got[gb+1] !== w1) begin nbad++; $display("FAIL midreset write1 got=%h want=%h", got[gb+1], w1); end
      end
      rst = 1'b0;
      repeat (3) begin @(negedge pclk); bus.cam_data = 8'($urandom); end
      @(negedge pclk) bus.cam_href = 1'b0;
      repeat (3) @(negedge pclk);
      for (int i = 0; i < 8; i++) begin
         @(negedge pclk);
         bus.cam_href = 1'b1; bus.cam_data = 8'($urandom);
      end
      @(negedge pclk) bus.cam_href = 1'b0;
      repeat (3) @(negedge pclk);
      bus.cam_vsync = 1'b1;
      repeat (5) @(negedge pclk);
      total++; if (got.size() - gb != 2) begin nbad++; $display("FAIL midreset writes_before_sync got=%0d want=0", got.size() - gb - 2); end
      total++; if (done_cnt + err_cnt != db + eb) begin nbad++; $display("FAIL midreset pulses_before_sync got=%0d want=0", done_cnt + err_cnt - db - eb); end
      gb = got.size();
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      add_line(8, 0);
      add_line(8, 0);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL midreset count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL midreset write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL midreset done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL midreset err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL midreset back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_back_to_back();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      exp.delete(); exp_done = 0; exp_err = 0;
      new_frame();
      add_line(8, 0);
      add_line(8, 0);
      model_frame();
      run_frame(1);
      new_frame();
      add_line(8, 0);
      add_line(8, 0);
      model_frame();
      run_frame(0);
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL b2b count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL b2b write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL b2b done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL b2b err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL b2b back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   task automatic test_random_frames();
      int gb = got.size(), db = done_cnt, eb = err_cnt, cb = consec;
      int lens[6] = '{6, 7, 8, 8, 8, 10};
      exp.delete(); exp_done = 0; exp_err = 0;
      for (int f = 0; f < 8; f++) begin
         new_frame();
         repeat ($urandom_range(1, 3)) add_line(lens[$urandom_range(0, 5)], 0);
         model_frame();
         run_frame(0);
      end
      total++;
      if (got.size() - gb != exp.size()) begin nbad++; $display("FAIL random count got=%0d want=%0d", got.size() - gb, exp.size()); end
      for (int i = 0; i < exp.size(); i++) if (gb + i < got.size()) begin
         total++;
         if (got[gb+i] !== exp[i]) begin nbad++; $display("FAIL random write%0d got=%h want=%h", i, got[gb+i], exp[i]); end
      end
      total++; if (done_cnt - db != exp_done) begin nbad++; $display("FAIL random done got=%0d want=%0d", done_cnt - db, exp_done); end
      total++; if (err_cnt - eb != exp_err) begin nbad++; $display("FAIL random err got=%0d want=%0d", err_cnt - eb, exp_err); end
      total++; if (consec - cb != 0) begin nbad++; $display("FAIL random back_to_back_wen got=%0d want=0", consec - cb); end
   endtask

   initial begin
      bus.cam_vsync = 1'b1;
      bus.cam_href  = 1'b0;
      bus.cam_data  = 8'h00;
      test_reset();
      test_clean_frame();
      test_startup_midframe();
      test_odd_line();
      test_overlong();
      test_reset_midline();
      test_back_to_back();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, nbad);
      $finish;
   end
endmodule
